qspi_flash_responder: RTL and testbench
=======================================

QSPI_FLASH_RESPONDER -- requirements
Module: qspi_flash_responder

Interface
REQ-001 Parameter: ID_BYTES, 24'h20BA18, JEDEC ID returned by RDID, MSB byte first.
REQ-002 Parameter: MEM_AW, 8, address width of internal byte array (2^MEM_AW bytes).
REQ-003 Port: clk  input  1  system clock, rising edge; all state synchronous to it.
REQ-004 Port: RESET  input  1  reset, synchronous, active-high.
REQ-005 Port: SCK  input  1  serial clock from initiator, asynchronous to clk.
REQ-006 Port: S  input  1  chip select, active-low, asynchronous.
REQ-007 Port: dq_in  input  4  DQ[3:0] pin inputs, asynchronous.
REQ-008 Port: dq_out  output  4  DQ[3:0] drive values.
REQ-009 Port: dq_oe  output  4  per-bit output enables, 1 = drive.
REQ-010 Port: quad  output  1  quad protocol active.
REQ-011 Port: wel  output  1  write-enable latch.
REQ-012 Port: cmd_strobe  output  1  one-clk pulse when a command byte completes.
REQ-013 Port: last_cmd  output  8  most recent command byte.

Function
REQ-014 SCK, S, dq_in shall pass through 2-flop synchronizers; SCK edges detected from synchronized history.
REQ-015 SPI mode 0: sample inputs on SCK rising, update dq_out on SCK falling, within 3 clk of the pin edge; supported SCK half-period >= 4 clk.
REQ-016 States: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE; S low from IDLE -> CMD with bit counter cleared.
REQ-017 Bits per rising edge: 1 on dq_in[0] when quad=0; 4 on dq_in[3:0], MSB nibble first, when quad=1 — for all phases (cmd, addr, data).
REQ-018 Output phase: quad=0 drives dq_out[1], dq_oe=4'b0010; quad=1 drives dq_out[3:0], dq_oe=4'hF; MSB first.
REQ-019 Command byte complete: cmd_strobe=1 one clk, last_cmd updated, decode:
- 0x9F RDID -> RDATA: ID bytes, then 0x00 repeated.
- 0x05 RDSR -> RDATA: {6'b0, wel, 1'b0} repeated.
- 0x06 WREN: wel<=1 at S rise; 0x04 WRDI: wel<=0 at S rise.
- 0x61 WRVECR -> WDATA 1 byte; if wel=1, quad<=~data[7] at S rise.
- 0x02 PP -> ADDR (3 bytes) -> WDATA; each complete byte written to array if wel=1.
- 0x03 READ -> ADDR (3 bytes) -> RDATA from array.
- any other -> IGNORE until S high.
REQ-020 Address: low MEM_AW bits of 24-bit address used; increments after each byte, wraps 2^MEM_AW-1 -> 0.
REQ-021 PP/WRVECR clear wel at S rise if wel was 1; partial bytes discarded.
REQ-022 First output bit of RDATA shall appear after the falling SCK edge following the last command/address bit.
REQ-023 S high in any state: abort, state<=IDLE, dq_oe<=0 within 3 clk of pin edge; pending WEL/quad updates applied only at this S rise.
REQ-024 SCK edges while S high ignored; array write and S rise in same clk: write completes first.

Reset
REQ-025 RESET: state=IDLE, quad=0, wel=0, dq_oe=0, dq_out=0, cmd_strobe=0, last_cmd=0, counters cleared; array contents not reset.
REQ-026 RESET mid-transaction overrides all; responder idles until next S falling edge after RESET low.

Verification
REQ-027 RDID single-line, 32 SCK -> DQ1 returns 0x20, 0xBA, 0x18, then 0x00; cmd_strobe once, last_cmd=0x9F.
REQ-028 WREN, then WRVECR data 0x4F -> quad=1, wel=0; RDSR in quad -> 0x00 on DQ[3:0], dq_oe=4'hF.
REQ-029 Quad WREN, PP addr 0xA30000 data DE AD BE EF; READ 0xA30000 4 bytes -> DE AD BE EF.
REQ-030 PP with wel=0 at addr 0x10 data 0x55 -> READ 0x10 returns prior value, unchanged.
REQ-031 READ addr 0x0000FE, 4 bytes -> bytes from 0xFE, 0xFF, 0x00, 0x01 (wrap).
REQ-032 S raised after 5 bits of PP data byte, and RESET mid-READ -> no write, dq_oe=0 within 3 clk, next RDID correct.

Source files
------------

// File: rtl/qspi_flash_responder.sv
// QSPI flash responder: a small SPI/QSPI NOR-flash target model (RDID, RDSR, WREN,
// WRDI, WRVECR, PP, READ) backed by an internal byte array, oversampled on clk.
`timescale 1ns/1ps
module qspi_flash_responder #(
  parameter logic [23:0] ID_BYTES = 24'h20BA18,
  parameter int unsigned MEM_AW   = 8
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       SCK,
  input  logic       S,
  input  logic [3:0] dq_in,
  output logic [3:0] dq_out,
  output logic [3:0] dq_oe,
  output logic       quad,
  output logic       wel,
  output logic       cmd_strobe,
  output logic [7:0] last_cmd
);

  localparam logic [7:0] CmdRdid   = 8'h9F;
  localparam logic [7:0] CmdRdsr   = 8'h05;
  localparam logic [7:0] CmdWren   = 8'h06;
  localparam logic [7:0] CmdWrdi   = 8'h04;
  localparam logic [7:0] CmdWrvecr = 8'h61;
  localparam logic [7:0] CmdPp     = 8'h02;
  localparam logic [7:0] CmdRead   = 8'h03;

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StWdata, StRdata, StIgnore} state_e;

  // Synchronizers and edge history
  logic [1:0] sck_sync_q, s_sync_q;
  logic [3:0] dq_sync1_q, dq_sync2_q;
  logic       sck_prev_q, s_prev_q;
  logic       sck_rise, sck_fall, s_high, s_rise, s_fall;

  // Protocol state
  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  out_sh_q, out_sh_d;
  logic [3:0]  out_cnt_q, out_cnt_d;
  logic [1:0]  id_idx_q, id_idx_d;
  logic        pend_wel_vld_q, pend_wel_vld_d, pend_wel_val_q, pend_wel_val_d;
  logic        pend_quad_vld_q, pend_quad_vld_d, pend_quad_val_q, pend_quad_val_d;
  logic        quad_q, quad_d, wel_q, wel_d, strobe_q, strobe_d;
  logic [7:0]  last_cmd_q, last_cmd_d;
  logic [3:0]  dq_out_q, dq_out_d, dq_oe_q, dq_oe_d;

  // Datapath helpers
  logic [3:0]  step, cnt_nxt, ocnt_nxt;
  logic [7:0]  shift_nxt, src_byte, cur_byte;
  logic        in_phase, byte_done;
  logic        mem_we;
  logic [7:0]  mem [0:(2**MEM_AW)-1];
  logic [7:0]  mem_rdata;

  // Bring asynchronous pins into the clk domain; s_prev is forced low in reset so a
  // chip select already held low after reset is not mistaken for a new falling edge.
  always_ff @(posedge clk) begin
    sck_sync_q <= {sck_sync_q[0], SCK};
    s_sync_q   <= {s_sync_q[0], S};
    dq_sync1_q <= dq_in;
    dq_sync2_q <= dq_sync1_q;
    sck_prev_q <= sck_sync_q[1];
    if (RESET) s_prev_q <= 1'b0;
    else       s_prev_q <= s_sync_q[1];
  end

  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q[1] & sck_prev_q;
  assign s_high   = s_sync_q[1];
  assign s_rise   = s_sync_q[1] & ~s_prev_q;
  assign s_fall   = ~s_sync_q[1] & s_prev_q;

  assign step      = quad_q ? 4'd4 : 4'd1;
  assign shift_nxt = quad_q ? {shift_q[3:0], dq_sync2_q} : {shift_q[6:0], dq_sync2_q[0]};
  assign cnt_nxt   = bit_cnt_q + step;
  assign ocnt_nxt  = out_cnt_q + step;
  assign in_phase  = (state_q == StCmd) || (state_q == StAddr) || (state_q == StWdata);
  assign byte_done = in_phase && sck_rise && (cnt_nxt == 4'd8);
  assign mem_rdata = mem[addr_q[MEM_AW-1:0]];
  assign cur_byte  = (out_cnt_q == 4'd0) ? src_byte : out_sh_q;

  // Select the byte the read phase is currently streaming out
  always_comb begin
    src_byte = mem_rdata;
    if (last_cmd_q == CmdRdid) begin
      unique case (id_idx_q)
        2'd0:    src_byte = ID_BYTES[23:16];
        2'd1:    src_byte = ID_BYTES[15:8];
        2'd2:    src_byte = ID_BYTES[7:0];
        default: src_byte = 8'h00;
      endcase
    end else if (last_cmd_q == CmdRdsr) begin
      src_byte = {6'b0, wel_q, 1'b0};
    end
  end

  // Next-state logic: command decode, address/data collection, read streaming, abort
  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    byte_cnt_d      = byte_cnt_q;
    addr_d          = addr_q;
    out_sh_d        = out_sh_q;
    out_cnt_d       = out_cnt_q;
    id_idx_d        = id_idx_q;
    pend_wel_vld_d  = pend_wel_vld_q;
    pend_wel_val_d  = pend_wel_val_q;
    pend_quad_vld_d = pend_quad_vld_q;
    pend_quad_val_d = pend_quad_val_q;
    quad_d          = quad_q;
    wel_d           = wel_q;
    strobe_d        = 1'b0;
    last_cmd_d      = last_cmd_q;
    dq_out_d        = dq_out_q;
    dq_oe_d         = dq_oe_q;
    mem_we          = 1'b0;

    if (in_phase && sck_rise) begin
      shift_d   = shift_nxt;
      bit_cnt_d = byte_done ? 4'd0 : cnt_nxt;
    end

    unique case (state_q)
      StIdle: begin
        if (s_fall) begin
          state_d    = StCmd;
          shift_d    = 8'h00;
          bit_cnt_d  = 4'd0;
          byte_cnt_d = 2'd0;
          out_cnt_d  = 4'd0;
          id_idx_d   = 2'd0;
        end
      end
      StCmd: begin
        if (byte_done) begin
          strobe_d   = 1'b1;
          last_cmd_d = shift_nxt;
          case (shift_nxt)
            CmdRdid, CmdRdsr: state_d = StRdata;
            CmdWren: begin
              pend_wel_vld_d = 1'b1;
              pend_wel_val_d = 1'b1;
              state_d        = StIgnore;
            end
            CmdWrdi: begin
              pend_wel_vld_d = 1'b1;
              pend_wel_val_d = 1'b0;
              state_d        = StIgnore;
            end
            CmdWrvecr, CmdPp, CmdRead: begin
              // Program-type commands consume the latch when the select rises
              if (shift_nxt != CmdRead && wel_q) begin
                pend_wel_vld_d = 1'b1;
                pend_wel_val_d = 1'b0;
              end
              state_d = (shift_nxt == CmdWrvecr) ? StWdata : StAddr;
            end
            default: state_d = StIgnore;
          endcase
        end
      end
      StAddr: begin
        if (byte_done) begin
          addr_d     = {addr_q[15:0], shift_nxt};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd2) state_d = (last_cmd_q == CmdRead) ? StRdata : StWdata;
        end
      end
      StWdata: begin
        if (byte_done) begin
          if (last_cmd_q == CmdPp) begin
            mem_we = wel_q;
            addr_d = addr_q + 24'd1;
          end else begin
            if (wel_q) begin
              pend_quad_vld_d = 1'b1;
              pend_quad_val_d = ~shift_nxt[7];
            end
            state_d = StIgnore;
          end
        end
      end
      StRdata: begin
        if (sck_fall) begin
          dq_oe_d  = quad_q ? 4'hF : 4'b0010;
          dq_out_d = quad_q ? cur_byte[7:4] : {2'b00, cur_byte[7], 1'b0};
          out_sh_d = quad_q ? {cur_byte[3:0], 4'h0} : {cur_byte[6:0], 1'b0};
          if (ocnt_nxt == 4'd8) begin
            out_cnt_d = 4'd0;
            addr_d    = addr_q + 24'd1;
            if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
          end else begin
            out_cnt_d = ocnt_nxt;
          end
        end
      end
      StIgnore: state_d = StIgnore;
      default:  state_d = StIdle;
    endcase

    // Deferred register updates take effect only on the select rising edge
    if (s_rise) begin
      if (pend_wel_vld_d)  wel_d  = pend_wel_val_d;
      if (pend_quad_vld_d) quad_d = pend_quad_val_d;
      pend_wel_vld_d  = 1'b0;
      pend_quad_vld_d = 1'b0;
    end

    if (s_high) begin
      state_d = StIdle;
      dq_oe_d = 4'h0;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q         <= StIdle;
      shift_q         <= 8'h00;
      bit_cnt_q       <= 4'd0;
      byte_cnt_q      <= 2'd0;
      addr_q          <= 24'h0;
      out_sh_q        <= 8'h00;
      out_cnt_q       <= 4'd0;
      id_idx_q        <= 2'd0;
      pend_wel_vld_q  <= 1'b0;
      pend_wel_val_q  <= 1'b0;
      pend_quad_vld_q <= 1'b0;
      pend_quad_val_q <= 1'b0;
      quad_q          <= 1'b0;
      wel_q           <= 1'b0;
      strobe_q        <= 1'b0;
      last_cmd_q      <= 8'h00;
      dq_out_q        <= 4'h0;
      dq_oe_q         <= 4'h0;
    end else begin
      state_q         <= state_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      byte_cnt_q      <= byte_cnt_d;
      addr_q          <= addr_d;
      out_sh_q        <= out_sh_d;
      out_cnt_q       <= out_cnt_d;
      id_idx_q        <= id_idx_d;
      pend_wel_vld_q  <= pend_wel_vld_d;
      pend_wel_val_q  <= pend_wel_val_d;
      pend_quad_vld_q <= pend_quad_vld_d;
      pend_quad_val_q <= pend_quad_val_d;
      quad_q          <= quad_d;
      wel_q           <= wel_d;
      strobe_q        <= strobe_d;
      last_cmd_q      <= last_cmd_d;
      dq_out_q        <= dq_out_d;
      dq_oe_q         <= dq_oe_d;
    end
  end

  // Byte array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we && !RESET) mem[addr_q[MEM_AW-1:0]] <= shift_nxt;
  end

  assign dq_out     = dq_out_q;
  assign dq_oe      = dq_oe_q;
  assign quad       = quad_q;
  assign wel        = wel_q;
  assign cmd_strobe = strobe_q;
  assign last_cmd   = last_cmd_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Randomized bench for qspi_flash_responder with a transaction-level flash model.
`timescale 1ns/1ps
module tb_qspi_flash_responder;

  localparam int unsigned Half    = 5;  // clk cycles per SCK half-period
  localparam logic [23:0] IdBytes = 24'h20BA18;

  logic       clk = 1'b0;
  logic       RESET, SCK, S;
  logic [3:0] dq_in, dq_out, dq_oe;
  logic       quad, wel, cmd_strobe;
  logic [7:0] last_cmd;

  qspi_flash_responder #(.ID_BYTES(IdBytes), .MEM_AW(8)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .SCK        (SCK),
    .S          (S),
    .dq_in      (dq_in),
    .dq_out     (dq_out),
    .dq_oe      (dq_oe),
    .quad       (quad),
    .wel        (wel),
    .cmd_strobe (cmd_strobe),
    .last_cmd   (last_cmd)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned strobe_cnt = 0;

  always @(posedge clk) if (cmd_strobe) strobe_cnt <= strobe_cnt + 1;

  // Reference model state
  logic [7:0] m_mem [256];
  logic       m_quad, m_wel;
  logic [7:0] wbuf [256];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] id_byte(input int i);
    logic [23:0] id;
    id = IdBytes;
    return (i < 3) ? id[23-8*i -: 8] : 8'h00;
  endfunction

  // Clock out n slices (bits or nibbles) of tx; capture what the responder drives
  task automatic xfer_n(input logic [7:0] tx, input int n, output logic [7:0] rx,
                        output logic [3:0] oe);
    rx = 8'h00;
    oe = 4'h0;
    for (int i = 0; i < n; i++) begin
      if (m_quad) dq_in = tx[7-4*i -: 4];
      else        dq_in = {3'($urandom_range(0, 7)), tx[7-i]};
      wait_clk(Half);
      rx  = m_quad ? {rx[3:0], dq_out} : {rx[6:0], dq_out[1]};
      oe  = dq_oe;
      SCK = 1'b1;
      wait_clk(Half);
      SCK = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic [3:0] oe);
    xfer_n(tx, m_quad ? 2 : 8, rx, oe);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] rx;
    logic [3:0] oe;
    xfer(a[23:16], rx, oe);
    xfer(a[15:8], rx, oe);
    xfer(a[7:0], rx, oe);
  endtask

  task automatic end_txn();
    wait_clk(Half);
    S = 1'b1;
    wait_clk(2 * Half);
  endtask

  task automatic post_checks(input logic [7:0] cmd, input int unsigned s0);
    check_eq("strobe_count", strobe_cnt - s0, 1);
    check_eq("last_cmd", last_cmd, cmd);
    check_eq("quad", quad, m_quad);
    check_eq("wel", wel, m_wel);
  endtask

  // Single-byte commands plus optional trailing bytes that must be ignored
  task automatic op_simple(input logic [7:0] cmd, input int junk);
    logic [7:0] rx;
    logic [3:0] oe;
    int unsigned s0;
    s0 = strobe_cnt;
    S  = 1'b0;
    wait_clk(Half);
    xfer(cmd, rx, oe);
    for (int i = 0; i < junk; i++) begin
      xfer(8'($urandom), rx, oe);
      check_eq("ignored_oe", oe, 4'h0);
    end
    end_txn();
    if (cmd == 8'h06)      m_wel = 1'b1;
    else if (cmd == 8'h04) m_wel = 1'b0;
    post_checks(cmd, s0);
  endtask

  // RDID / RDSR / READ with n data bytes returned
  task automatic op_rd(input logic [7:0] cmd, input logic [23:0] a, input int n);
    logic [7:0] rx, exp;
    logic [3:0] oe;
    int unsigned s0;
    s0 = strobe_cnt;
    S  = 1'b0;
    wait_clk(Half);
    xfer(cmd, rx, oe);
    if (cmd == 8'h03) send_addr(a);
    for (int i = 0; i < n; i++) begin
      xfer(8'($urandom), rx, oe);
      if (cmd == 8'h9F)      exp = id_byte(i);
      else if (cmd == 8'h05) exp = {6'b0, m_wel, 1'b0};
      else                   exp = m_mem[8'(a + 24'(i))];
      check_eq(cmd == 8'h9F ? "rdid_byte" : cmd == 8'h05 ? "rdsr_byte" : "read_byte", rx, exp);
      check_eq("read_oe", oe, m_quad ? 4'hF : 4'b0010);
    end
    end_txn();
    post_checks(cmd, s0);
  endtask

  task automatic op_pp(input logic [23:0] a, input int n);
    logic [7:0] rx;
    logic [3:0] oe;
    int unsigned s0;
    s0 = strobe_cnt;
    S  = 1'b0;
    wait_clk(Half);
    xfer(8'h02, rx, oe);
    send_addr(a);
    for (int i = 0; i < n; i++) xfer(wbuf[i], rx, oe);
    end_txn();
    if (m_wel) begin
      for (int i = 0; i < n; i++) m_mem[8'(a + 24'(i))] = wbuf[i];
      m_wel = 1'b0;
    end
    post_checks(8'h02, s0);
  endtask

  // PP whose first data byte is cut short after nbits slices
  task automatic op_pp_abort(input logic [23:0] a, input logic [7:0] d, input int nbits);
    logic [7:0] rx;
    logic [3:0] oe;
    int unsigned s0;
    s0 = strobe_cnt;
    S  = 1'b0;
    wait_clk(Half);
    xfer(8'h02, rx, oe);
    send_addr(a);
    xfer_n(d, nbits, rx, oe);
    end_txn();
    m_wel = 1'b0;
    post_checks(8'h02, s0);
  endtask

  task automatic op_wrvecr(input logic [7:0] d);
    logic [7:0] rx;
    logic [3:0] oe;
    int unsigned s0;
    s0 = strobe_cnt;
    S  = 1'b0;
    wait_clk(Half);
    xfer(8'h61, rx, oe);
    xfer(d, rx, oe);
    end_txn();
    if (m_wel) begin
      m_quad = ~d[7];
      m_wel  = 1'b0;
    end
    post_checks(8'h61, s0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rx, c;
    logic [3:0]  oe;
    logic [23:0] a;
    int unsigned op, n, s0;

    RESET = 1'b1;
    S     = 1'b1;
    SCK   = 1'b0;
    dq_in = 4'h0;
    m_quad = 1'b0;
    m_wel  = 1'b0;
    wait_clk(5);
    check_eq("rst_dq_oe", dq_oe, 4'h0);
    check_eq("rst_dq_out", dq_out, 4'h0);
    check_eq("rst_quad", quad, 1'b0);
    check_eq("rst_wel", wel, 1'b0);
    check_eq("rst_strobe", cmd_strobe, 1'b0);
    check_eq("rst_last_cmd", last_cmd, 8'h00);
    RESET = 1'b0;
    wait_clk(10);

    // JEDEC ID over a single line
    op_rd(8'h9F, 24'h0, 4);

    // Enter quad mode through the volatile config register
    op_simple(8'h06, 0);
    op_wrvecr(8'h4F);
    check_eq("quad_entered", quad, 1'b1);
    op_rd(8'h05, 24'h0, 2);

    // Fill the whole array so every later read has a known expectation
    for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
    wbuf[16] = 8'hAA;
    op_simple(8'h06, 0);
    op_pp(24'h000000, 256);

    // Quad page program and read-back
    wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
    op_simple(8'h06, 0);
    op_pp(24'hA30000, 4);
    op_rd(8'h03, 24'hA30000, 4);

    // Program without the write latch leaves the array untouched
    wbuf[0] = 8'h55;
    op_pp(24'h000010, 1);
    op_rd(8'h03, 24'h000010, 1);

    // Address wrap at the top of the array
    op_rd(8'h03, 24'h0000FE, 4);

    // Random command mix
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 7);
      a  = {8'($urandom), 8'($urandom), 8'($urandom)};
      if ($urandom_range(0, 3) == 0) a[7:0] = 8'($urandom_range(250, 255));
      n  = $urandom_range(1, 4);
      case (op)
        0: op_simple(8'h06, 0);
        1: op_simple(8'h04, $urandom_range(0, 1));
        2: op_rd(8'h05, 24'h0, n);
        3: op_rd(8'h9F, 24'h0, n + 1);
        4: begin
          for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
          if ($urandom_range(0, 3) != 0) op_simple(8'h06, 0);
          op_pp(a, n);
        end
        5: op_rd(8'h03, a, n);
        6: begin
          if ($urandom_range(0, 1) == 0) op_simple(8'h06, 0);
          op_wrvecr(8'($urandom));
        end
        default: begin
          do c = 8'($urandom);
          while (c inside {8'h9F, 8'h05, 8'h06, 8'h04, 8'h61, 8'h02, 8'h03});
          op_simple(c, 2);
        end
      endcase
    end

    // Back to single line, then a PP cut off after 5 data bits
    op_simple(8'h06, 0);
    op_wrvecr(8'hFF);
    check_eq("single_line", quad, 1'b0);
    a = {16'h0, 8'($urandom)};
    op_simple(8'h06, 0);
    op_pp_abort(a, ~m_mem[a[7:0]], 5);
    op_rd(8'h03, a, 1);

    // Select raised in the middle of a read byte releases the bus quickly
    S = 1'b0;
    wait_clk(Half);
    xfer(8'h03, rx, oe);
    send_addr(24'h000040);
    xfer(8'h00, rx, oe);
    check_eq("abort_read_byte", rx, m_mem[8'h40]);
    xfer_n(8'h00, 3, rx, oe);
    check_eq("abort_oe_before", oe, 4'b0010);
    S = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_oe_3clk", dq_oe, 4'h0);
    wait_clk(2 * Half);

    // Reset in the middle of a quad read
    op_simple(8'h06, 0);
    op_wrvecr(8'h00);
    op_simple(8'h06, 0);
    S = 1'b0;
    wait_clk(Half);
    xfer(8'h03, rx, oe);
    send_addr(24'h000080);
    xfer(8'h00, rx, oe);
    check_eq("rst_read_byte", rx, m_mem[8'h80]);
    xfer_n(8'h00, 1, rx, oe);
    RESET = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("midrst_oe", dq_oe, 4'h0);
    check_eq("midrst_quad", quad, 1'b0);
    check_eq("midrst_wel", wel, 1'b0);
    @(negedge clk);
    RESET  = 1'b0;
    m_quad = 1'b0;
    m_wel  = 1'b0;
    // Select still low: clocking a command must not be decoded
    s0 = strobe_cnt;
    xfer(8'h9F, rx, oe);
    xfer(8'h00, rx, oe);
    check_eq("post_rst_idle_strobe", strobe_cnt - s0, 0);
    check_eq("post_rst_idle_oe", dq_oe, 4'h0);
    end_txn();
    op_rd(8'h9F, 24'h0, 4);
    op_rd(8'h03, 24'h0000FE, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
